video_sobel_edge_stream: RTL and testbench

Streaming 3×3 Sobel edge detector for the FPGA-side video pipeline of the DE10-Standard Computer System. It consumes an 8-bit grayscale Avalon-ST video stream, for example from the pixel-buffer DMA after RGB-to-gray conversion. It produces an 8-bit edge-magnitude or binary edge stream with identical frame dimensions and packet framing, which feeds the scaler and dual-clock FIFO in front of the VGA controller. It uses two internal line buffers and needs no external memory.

---
 rtl/video_edge_pkg.sv | 36 +++
 rtl/video_line_buffer.sv | 33 +++
 rtl/video_sobel_edge_stream.sv | 176 +++++++++++++++++
 tb/tb_video_sobel_edge_stream.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_edge_pkg.sv
// Shared widths, the 3x3 window type and the pixel/edge helper functions
// for the Sobel edge stream.
package video_edge_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;

    // Window indexed [row][col]: row 0 is line y-2, col 0 is column x-2.
    // Element [2][2] is always the most recently accepted pixel.
    typedef logic [2:0][2:0][PIX_W-1:0] win3x3_t;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic logic signed [GRAD_W-1:0] widen(input logic [PIX_W-1:0] p);
        return signed'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    // Border forcing, saturation and optional thresholding of a gradient
    // magnitude into an output pixel.
    function automatic logic [PIX_W-1:0] edge_pixel(
        input logic [GRAD_W-1:0] mag,
        input logic              border,
        input logic [PIX_W-1:0]  thresh,
        input logic              binary
    );
        logic [PIX_W-1:0] sat;
        sat = (mag > GRAD_W'(255)) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
        if (border) begin
            return '0;
        end else if (binary) begin
            return (sat > thresh) ? {PIX_W{1'b1}} : '0;
        end else begin
            return sat;
        end
    endfunction

endpackage

// File: rtl/video_line_buffer.sv
// One video line of pixels: simple dual-port RAM, synchronous read,
// read-during-write to the same address returns the old contents.
module video_line_buffer
    import video_edge_pkg::*;
#(
    parameter int WIDTH = 320,
    parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [WIDTH];
    logic [PIX_W-1:0] rdata_q;

    // Write port and registered read port; the read sees pre-write data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector on an 8-bit Avalon-ST gray stream.
// Handshake: a beat moves across an interface on a clock edge where valid
// and ready are both high; stream_out_* hold steady while valid && !ready,
// and the whole pipeline advances only when adv = !out_valid || out_ready.
module video_sobel_edge_stream
    import video_edge_pkg::*;
#(
    parameter int         WIDTH  = 320,
    parameter logic [7:0] THRESH = 8'd128,
    parameter bit         BINARY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bypass,
    input  logic [PIX_W-1:0] stream_in_data,
    input  logic             stream_in_startofpacket,
    input  logic             stream_in_endofpacket,
    input  logic             stream_in_valid,
    output logic             stream_in_ready,
    output logic [PIX_W-1:0] stream_out_data,
    output logic             stream_out_startofpacket,
    output logic             stream_out_endofpacket,
    output logic             stream_out_valid,
    input  logic             stream_out_ready
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = 10;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX  = '1;

    logic             adv, accept;
    logic [XW-1:0]    x_q, x_d, pos_x;
    logic [YW-1:0]    y_q, y_d, pos_y;
    logic             byp_q, byp_cur;
    // S1: accepted beat plus line-buffer read data (held inside the RAMs)
    logic             v1_q, sop1_q, eop1_q, byp1_q;
    logic [PIX_W-1:0] pix1_q;
    logic [XW-1:0]    x1_q;
    logic [YW-1:0]    y1_q;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    // Window of the last beat that left S1, and the window of the S1 beat
    win3x3_t          win_q, win_new;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0] ax, ay, mag;
    logic             border;
    logic [PIX_W-1:0] s2_data;
    // S2: output register
    logic             out_valid_q, out_sop_q, out_eop_q;
    logic [PIX_W-1:0] out_data_q;

    assign adv             = !out_valid_q || stream_out_ready;
    assign stream_in_ready = adv & !reset;
    assign accept          = stream_in_valid & stream_in_ready;

    // Pixel position of the incoming beat and the counters that follow it.
    always_comb begin
        pos_x   = stream_in_startofpacket ? '0 : x_q;
        pos_y   = stream_in_startofpacket ? '0 : y_q;
        byp_cur = stream_in_startofpacket ? bypass : byp_q;
        x_d     = pos_x + XW'(1);
        y_d     = pos_y;
        if (pos_x == X_LAST) begin
            x_d = '0;
            y_d = (pos_y == Y_MAX) ? pos_y : pos_y + YW'(1);
        end
    end

    // Frame counters and per-frame bypass mode, updated on every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            byp_q <= 1'b0;
        end else if (accept) begin
            x_q <= x_d;
            y_q <= y_d;
            if (stream_in_startofpacket) begin
                byp_q <= bypass;
            end
        end
    end

    // S1 register: captures the accepted beat, drains when S2 takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            sop1_q <= 1'b0;
            eop1_q <= 1'b0;
            byp1_q <= 1'b0;
            pix1_q <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
        end else if (adv) begin
            v1_q <= accept;
            if (accept) begin
                sop1_q <= stream_in_startofpacket;
                eop1_q <= stream_in_endofpacket;
                byp1_q <= byp_cur;
                pix1_q <= stream_in_data;
                x1_q   <= pos_x;
                y1_q   <= pos_y;
            end
        end
    end

    // LB0 takes the new pixel immediately; LB1 takes the old LB0 value once
    // the read data exists, i.e. when the beat leaves S1.
    video_line_buffer #(.WIDTH(WIDTH), .AW(XW)) u_lb0 (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (pos_x),
        .wdata_i (stream_in_data),
        .re_i    (accept),
        .raddr_i (pos_x),
        .rdata_o (lb0_rd)
    );

    video_line_buffer #(.WIDTH(WIDTH), .AW(XW)) u_lb1 (
        .clk_i   (clk),
        .we_i    (adv & v1_q),
        .waddr_i (x1_q),
        .wdata_i (lb0_rd),
        .re_i    (accept),
        .raddr_i (pos_x),
        .rdata_o (lb1_rd)
    );

    // Shift left and insert the column {LB1, LB0, pixel} on the right.
    assign win_new[0] = {lb1_rd, win_q[0][2], win_q[0][1]};
    assign win_new[1] = {lb0_rd, win_q[1][2], win_q[1][1]};
    assign win_new[2] = {pix1_q, win_q[2][2], win_q[2][1]};

    // Commit the S1 beat's window as it moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
        end else if (adv && v1_q) begin
            win_q <= win_new;
        end
    end

    // Sobel gradients, magnitude and output pixel selection for the S1 beat.
    always_comb begin
        gx = (widen(win_new[0][2]) + (widen(win_new[1][2]) <<< 1) + widen(win_new[2][2]))
           - (widen(win_new[0][0]) + (widen(win_new[1][0]) <<< 1) + widen(win_new[2][0]));
        gy = (widen(win_new[2][0]) + (widen(win_new[2][1]) <<< 1) + widen(win_new[2][2]))
           - (widen(win_new[0][0]) + (widen(win_new[0][1]) <<< 1) + widen(win_new[0][2]));
        ax      = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
        ay      = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = ax + ay;
        border  = (x1_q < XW'(2)) || (y1_q < YW'(2));
        s2_data = byp1_q ? pix1_q : edge_pixel(mag, border, THRESH, BINARY);
    end

    // S2 output register, held while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v1_q;
            out_data_q  <= s2_data;
            out_sop_q   <= sop1_q & v1_q;
            out_eop_q   <= eop1_q & v1_q;
        end
    end

    assign stream_out_valid         = out_valid_q;
    assign stream_out_data          = out_data_q;
    assign stream_out_startofpacket = out_sop_q;
    assign stream_out_endofpacket   = out_eop_q;

endmodule

// File: tb/tb_video_sobel_edge_stream.sv
// Bench for video_sobel_edge_stream: two instances (binary and magnitude
// output) share one input stream; expected beats are queued at accept time
// and popped by a monitor whenever an output beat is transferred.
module tb_video_sobel_edge_stream;

    localparam int W = 8;
    localparam int K_CONST = 0;
    localparam int K_VEDGE = 1;
    localparam int K_RAMP  = 2;
    localparam int K_RAND  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, bypass, in_sop, in_eop, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready_b, in_ready_m;
    logic [7:0] b_data, m_data;
    logic       b_sop, b_eop, b_valid, m_sop, m_eop, m_valid;

    video_sobel_edge_stream #(.WIDTH(W), .THRESH(8'd128), .BINARY(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bypass(bypass),
        .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
        .stream_in_endofpacket(in_eop), .stream_in_valid(in_valid),
        .stream_in_ready(in_ready_b),
        .stream_out_data(b_data), .stream_out_startofpacket(b_sop),
        .stream_out_endofpacket(b_eop), .stream_out_valid(b_valid),
        .stream_out_ready(out_ready)
    );

    video_sobel_edge_stream #(.WIDTH(W), .THRESH(8'd128), .BINARY(1'b0)) dut_m (
        .clk(clk), .reset(reset), .bypass(bypass),
        .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
        .stream_in_endofpacket(in_eop), .stream_in_valid(in_valid),
        .stream_in_ready(in_ready_m),
        .stream_out_data(m_data), .stream_out_startofpacket(m_sop),
        .stream_out_endofpacket(m_eop), .stream_out_valid(m_valid),
        .stream_out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_b_q[$];
    logic [9:0] exp_m_q[$];
    int  img[0:31][0:W-1];
    int  mx = 0, my = 0;
    bit  mbyp = 1'b0;
    bit  rand_ready = 1'b0;
    bit  measure_lat = 1'b0;
    bit  lat_armed = 1'b0;
    int  first_acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Golden Sobel on the current frame image.
    function automatic logic [7:0] sobel_ref(input int x, input int y, input bit binary);
        int gx, gy, mag;
        if (x < 2 || y < 2) return 8'h00;
        gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
        gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
           - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        if (binary) return (mag > 128) ? 8'hFF : 8'h00;
        return 8'(mag);
    endfunction

    // ---------------- sink ready driver ----------------
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // ---------------- monitor ----------------
    bit         held = 1'b0;
    logic [10:0] held_v;
    always @(negedge clk) begin
        logic [9:0] e;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) check("stall_stable", {b_valid, b_sop, b_eop, b_data}, held_v);
            held   = b_valid && !out_ready;
            held_v = {b_valid, b_sop, b_eop, b_data};
            if (b_valid && out_ready) begin
                if (lat_armed) begin
                    check("first_latency", cyc - first_acc_cyc, 2);
                    lat_armed = 1'b0;
                end
                checks++;
                if (exp_b_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat_b: actual=%0h required=none", {b_sop, b_eop, b_data});
                end else begin
                    checks--;
                    e = exp_b_q.pop_front();
                    check("out_binary", {b_sop, b_eop, b_data}, e);
                end
            end
            if (m_valid && out_ready) begin
                checks++;
                if (exp_m_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat_m: actual=%0h required=none", {m_sop, m_eop, m_data});
                end else begin
                    checks--;
                    e = exp_m_q.pop_front();
                    check("out_magnitude", {m_sop, m_eop, m_data}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [7:0] pix, input bit sop, input bit eop,
                             input bit use_model, input logic [7:0] hb, input logic [7:0] hm);
        int x, y, t;
        bit acc;
        logic [7:0] eb, em;
        if (sop) begin
            x = 0; y = 0; mbyp = bypass;
        end else begin
            x = mx; y = my;
        end
        if (y < 32) img[y][x] = pix;
        if (mbyp) begin
            eb = pix; em = pix;
        end else if (use_model) begin
            eb = sobel_ref(x, y, 1'b1); em = sobel_ref(x, y, 1'b0);
        end else begin
            eb = hb; em = hm;
        end
        in_data = pix; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        t = 0; acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready_b;
            if (acc) begin
                exp_b_q.push_back({sop, eop, eb});
                exp_m_q.push_back({sop, eop, em});
                if (measure_lat) begin
                    first_acc_cyc = cyc;
                    lat_armed = 1'b1;
                    measure_lat = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        if (x == W - 1) begin
            mx = 0; my = (y < 1023) ? y + 1 : y;
        end else begin
            mx = x + 1; my = y;
        end
    endtask

    // Sends `count` beats of a 4-row frame; optionally flips bypass at beat
    // toggle_at and optionally omits SOP on the first beat.
    task automatic send_frame(input int kind, input int count, input int toggle_at, input bit with_sop);
        int x, y;
        logic [7:0] pix, hb, hm;
        bit interior;
        for (int i = 0; i < count; i++) begin
            x = i % W;
            y = i / W;
            interior = (x >= 2) && (y >= 2);
            if (i == toggle_at) bypass = ~bypass;
            case (kind)
                K_CONST: begin pix = 8'd50; hb = 8'h00; hm = 8'h00; end
                K_VEDGE: begin
                    pix = (x >= 4) ? 8'd100 : 8'd0;
                    hb  = (y >= 2 && (x == 4 || x == 5)) ? 8'hFF : 8'h00;
                    hm  = (y >= 2 && (x == 4 || x == 5)) ? 8'd255 : 8'h00;
                end
                K_RAMP: begin
                    pix = 8'(20 * y);
                    hb  = interior ? 8'hFF : 8'h00;
                    hm  = interior ? 8'd160 : 8'h00;
                end
                default: begin pix = 8'($urandom_range(0, 255)); hb = 8'h00; hm = 8'h00; end
            endcase
            send_beat(pix, with_sop && (i == 0), i == 4 * W - 1, kind == K_RAND, hb, hm);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_b_q.size() != 0 || exp_m_q.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, exp_b_q.size() + exp_m_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; bypass = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready_b, 0);
        check("rst_out_valid", b_valid, 0);
        check("rst_out_data", b_data, 0);
        check("rst_out_flags", {b_sop, b_eop, m_sop, m_eop}, 0);
        check("rst_out_valid_m", m_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_b, 1);
        @(posedge clk); #1;

        // Flat frame: all zero, latency 2, SOP/EOP framing.
        measure_lat = 1'b1;
        send_frame(K_CONST, 4 * W, -1, 1'b1);
        drain("drain_const");

        // Vertical edge and vertical ramp with hand-derived values.
        send_frame(K_VEDGE, 4 * W, -1, 1'b1);
        drain("drain_vedge");
        send_frame(K_RAMP, 4 * W, -1, 1'b1);
        drain("drain_ramp");

        // Random pixels under random backpressure.
        rand_ready = 1'b1;
        send_frame(K_RAND, 4 * W, -1, 1'b1);
        drain("drain_random_bp");
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // Bypass frame with a mid-frame toggle, then a filtered frame with one.
        bypass = 1'b1;
        send_frame(K_RAND, 4 * W, 10, 1'b1);
        bypass = 1'b0;
        send_frame(K_VEDGE, 4 * W, 12, 1'b1);
        bypass = 1'b0;
        drain("drain_bypass");

        // Mid-frame SOP restart.
        send_frame(K_RAND, 19, -1, 1'b1);
        send_frame(K_VEDGE, 4 * W, -1, 1'b1);
        drain("drain_mid_sop");

        // Reset mid-frame with beats in flight, then a frame lacking SOP.
        send_frame(K_RAND, 13, -1, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_b_q.delete();
        exp_m_q.delete();
        mx = 0; my = 0; mbyp = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", b_valid, 0);
        check("midrst_in_ready", in_ready_b, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_frame(K_RAMP, 4 * W, -1, 1'b0);
        drain("drain_after_reset");
        send_frame(K_RAMP, 4 * W, -1, 1'b1);
        drain("drain_ramp_again");

        // Single-pixel frame.
        send_beat(8'd77, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        drain("drain_one_pixel");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
